sar_search: RTL and testbench



---
 rtl/sar_search_pkg.sv | 21 ++
 rtl/sar_search.sv | 149 ++++++++++++++
 tb/tb_sar_search.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/sar_search_pkg.sv
// ----------------------------------------------------------------------------
// sar_search_pkg
//   Shared definitions for the successive-approximation search controller:
//   FSM state encoding and the default search width.
//   Imported by: sar_search
// ----------------------------------------------------------------------------
package sar_search_pkg;

    // Default width of target, guess and result.
    localparam int unsigned DefaultW = 4;

    // Controller states. StWait is only reachable when the comparator path is
    // registered (SAR_PIPE_CMP_EN); it keeps the same encoding either way.
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StProbe = 2'd1,
        StWait  = 2'd2,
        StDone  = 2'd3
    } state_e;

endpackage

// File: rtl/sar_search.sv
// ----------------------------------------------------------------------------
// sar_search
//   Successive-approximation search controller. Recovers an unknown W-bit
//   target T by binary search against an external greater-than comparator
//   wired as gt_in = (T > guess).
//
//   Each probe of bit i drives guess = acc | ((1 << i) - 1): the bits already
//   decided above i, bit i cleared and every lower bit set. Then
//   T > guess  <=>  T >= acc | (1 << i), so gt_in directly decides bit i.
//   The guess therefore never exceeds 2^W - 2 and cannot overflow.
//
//   Configuration macro:
//     SAR_PIPE_CMP_EN  undefined: gt_in is combinational from guess and is
//                      sampled in the same PROBE cycle (latency W+1).
//                      defined:   comparator output is registered; every PROBE
//                      is followed by a WAIT cycle with guess held, and gt_in
//                      is sampled at the end of WAIT (latency 2W+1).
//
//   Ports:
//     clk        in   1  system clock, rising edge
//     reset_n    in   1  synchronous reset, active-low
//     start      in   1  begin a search; only sampled in IDLE
//     gt_in      in   1  comparator output, 1 when T > guess
//     guess      out  W  candidate value driven to comparator i0
//     ready      out  1  1 while in IDLE
//     done_tick  out  1  one-cycle pulse, result valid
//     result     out  W  recovered T, held until the next accepted start
// ----------------------------------------------------------------------------
module sar_search
    import sar_search_pkg::*;
#(
    parameter int unsigned W = DefaultW
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic         gt_in,
    output logic [W-1:0] guess,
    output logic         ready,
    output logic         done_tick,
    output logic [W-1:0] result
);

    // Bit index counter width; keep at least one bit for W == 1.
    localparam int unsigned IdxW = (W > 1) ? $clog2(W) : 1;

    state_e          state_q, state_d;
    logic [W-1:0]    acc_q, acc_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic [W-1:0]    result_q, result_d;

    logic [W-1:0]    bit_sel;      // one-hot at the bit under test
    logic [W-1:0]    low_ones;     // all ones below the bit under test
    logic [W-1:0]    probe_guess;
    logic [W-1:0]    acc_next;
    logic            decide;       // cycle in which gt_in is consumed

    assign bit_sel     = W'(1) << idx_q;
    assign low_ones    = bit_sel - W'(1);
    assign probe_guess = acc_q | low_ones;
    assign acc_next    = gt_in ? (acc_q | bit_sel) : acc_q;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            acc_q    <= '0;
            idx_q    <= IdxW'(W - 1);
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            idx_q    <= idx_d;
            result_q <= result_d;
        end
    end

    // ------------------------------------------------------------------------
    // Next state and outputs
    // ------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        idx_d     = idx_q;
        result_d  = result_q;
        guess     = '0;
        ready     = 1'b0;
        done_tick = 1'b0;
        decide    = 1'b0;

        unique case (state_q)
            StIdle: begin
                ready = 1'b1;
                if (start) begin
                    acc_d   = '0;
                    idx_d   = IdxW'(W - 1);
                    state_d = StProbe;
                end
            end

            StProbe: begin
                guess = probe_guess;
`ifdef SAR_PIPE_CMP_EN
                // Give the registered comparator a cycle to see this guess.
                state_d = StWait;
`else
                decide  = 1'b1;
`endif
            end

            StWait: begin
`ifdef SAR_PIPE_CMP_EN
                guess  = probe_guess;
                decide = 1'b1;
`else
                // Unreachable without the registered comparator path.
                state_d = StIdle;
`endif
            end

            StDone: begin
                guess     = acc_q;
                done_tick = 1'b1;
                state_d   = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase

        // Consume gt_in for the current bit and advance to the next one.
        if (decide) begin
            acc_d = acc_next;
            if (idx_q == '0) begin
                result_d = acc_next;
                state_d  = StDone;
            end else begin
                idx_d   = idx_q - IdxW'(1);
                state_d = StProbe;
            end
        end
    end

    assign result = result_q;

endmodule

// File: tb/tb_sar_search.sv
// ----------------------------------------------------------------------------
// tb_sar_search
//   Pairs sar_search (W=4) with a greater-than comparator against a constant
//   target. Expected results are queued when a start is accepted and compared
//   when done_tick fires; guesses, ready and timing are checked per cycle.
//   Define SAR_PIPE_CMP_EN for both files to exercise the registered path.
// ----------------------------------------------------------------------------
module tb_sar_search;

    localparam int W = 4;
`ifdef SAR_PIPE_CMP_EN
    localparam int Step = 2;
`else
    localparam int Step = 1;
`endif

    logic         clk;
    logic         reset_n;
    logic         start;
    logic         gt_in;
    logic [W-1:0] guess;
    logic         ready;
    logic         done_tick;
    logic [W-1:0] result;

    logic [W-1:0] target;
    logic [W-1:0] exp_q[$];

    int checks;
    int errors;

    sar_search #(.W(W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .gt_in     (gt_in),
        .guess     (guess),
        .ready     (ready),
        .done_tick (done_tick),
        .result    (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External comparator: i1 = target, i0 = guess.
`ifdef SAR_PIPE_CMP_EN
    always @(posedge clk) gt_in <= (target > guess);
`else
    assign gt_in = (target > guess);
`endif

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    // Scoreboard consumer: every done_tick must match a queued expectation.
    always @(negedge clk) begin
        if (reset_n && done_tick === 1'b1) begin
            if (exp_q.size() == 0) begin
                check_val("spurious_done", done_tick, 0);
            end else begin
                check_val("result", result, exp_q.pop_front());
            end
        end
    end

    // Run one search; called right after a negedge with the DUT idle.
    task automatic run_search(input logic [W-1:0] t, input bit hold_start);
        int          acc;
        int          g;
        logic [W-1:0] glist[W];
        acc = 0;
        for (int i = W - 1; i >= 0; i--) begin
            g = acc | ((1 << i) - 1);
            glist[W-1-i] = W'(g);
            if (int'(t) > g) acc = acc | (1 << i);
        end
        target = t;
        check_val("ready_before", ready, 1);
        start = 1'b1;
        @(posedge clk);
        exp_q.push_back(t);
        for (int j = 0; j < W * Step; j++) begin
            @(negedge clk);
            if (!hold_start) start = 1'b0;
            check_val("guess", guess, glist[j / Step]);
            check_val("ready_busy", ready, 0);
            check_val("done_early", done_tick, 0);
        end
        @(negedge clk);
        check_val("done_tick", done_tick, 1);
        check_val("ready_done", ready, 0);
        start = 1'b0;
        @(negedge clk);
        check_val("ready_after", ready, 1);
        check_val("done_after", done_tick, 0);
        check_val("guess_idle", guess, 0);
        check_val("result_held", result, t);
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        start   = 1'b0;
        target  = '0;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("rst_ready", ready, 1);
        check_val("rst_guess", guess, 0);
        check_val("rst_done", done_tick, 0);
        check_val("rst_result", result, 0);
        reset_n = 1'b1;
        @(negedge clk);

        // Directed cases: 9 gives guesses 7,11,9,8; then both extremes.
        run_search(4'd9, 1'b0);
        run_search(4'd0, 1'b0);
        run_search(4'd15, 1'b0);
        run_search(4'd6, 1'b0);

        // start held high while busy: one done_tick, no restart.
        run_search(4'd5, 1'b1);
        repeat (2) begin
            @(negedge clk);
            check_val("hold_idle_ready", ready, 1);
        end

        // Reset during the third probe aborts the search.
        run_search(4'd12, 1'b0);
        target = 4'd9;
        start  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (2 * Step) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        check_val("abort_ready", ready, 1);
        check_val("abort_guess", guess, 0);
        check_val("abort_result", result, 0);
        check_val("abort_done", done_tick, 0);
        reset_n = 1'b1;
        repeat (W * Step + 3) begin
            @(negedge clk);
            check_val("abort_no_done", done_tick, 0);
        end

        // Back-to-back sweep of every target.
        for (int t = 0; t < (1 << W); t++) begin
            run_search(W'(t), 1'b0);
        end

        @(negedge clk);
        check_val("pending", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Safety net against a hung run.
    initial begin
        #200000;
        $display("FAIL timeout: got 0 expected 1 (simulation did not finish)");
        $fatal(1, "timeout");
    end

endmodule
